// File: rtl/pid_controller_if.sv
// pid_controller_if: control parameters and feedback into the PID stage, duty command out.
interface pid_controller_if;
    logic        [7:0]  control_mode;
    logic signed [23:0] setpoint;
    logic signed [23:0] Kp;
    logic signed [23:0] Ki;
    logic signed [23:0] Kd;
    logic        [23:0] PWMLimit;
    logic        [23:0] IntegralLimit;
    logic        [23:0] deadband;
    logic signed [15:0] current_limit;
    logic signed [23:0] encoder0_position;
    logic signed [23:0] displacement;
    logic signed [15:0] current;
    logic signed [23:0] duty;
    logic               duty_valid;

    modport master (
        output control_mode, setpoint, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband,
               current_limit, encoder0_position, displacement, current,
        input  duty, duty_valid
    );

    modport slave (
        input  control_mode, setpoint, Kp, Ki, Kd, PWMLimit, IntegralLimit, deadband,
               current_limit, encoder0_position, displacement, current,
        output duty, duty_valid
    );
endinterface

// File: rtl/pid_controller.sv
// pid_controller: fixed-rate multi-cycle PID stage producing a signed 24-bit PWM duty.
// Optional macro PID_CURRENT_LIMIT_EN enables the over-current duty cutoff in CLAMP.
module pid_controller #(
    parameter int unsigned CLK_FREQ_HZ    = 16_000_000,
    parameter int unsigned UPDATE_FREQ_HZ = 1000,
    parameter int unsigned FRAC_BITS      = 0
) (
    input  logic            CLK,
    input  logic            reset,
    pid_controller_if.slave io_bus
);
    localparam int unsigned TICK_PERIOD = CLK_FREQ_HZ / UPDATE_FREQ_HZ;
    localparam int unsigned CNT_W       = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam int unsigned DW          = 24;
    localparam int unsigned EW          = 26;
    localparam int unsigned IW          = 32;
    localparam int unsigned PW          = 48;
    localparam int unsigned SW          = 50;

    localparam logic signed [EW-1:0] ERR_HI   = 26'sd8388607;
    localparam logic signed [EW-1:0] ERR_LO   = -26'sd8388607;
    localparam logic signed [SW-1:0] DUTY_MAX = 50'sd8388607;

    typedef enum logic [2:0] {
        S_IDLE, S_SAMPLE, S_DEADBAND, S_MUL_P, S_MUL_I, S_MUL_D, S_SUM, S_CLAMP
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]       r_tick_cnt;
    logic                   w_tick;
    logic [7:0]             r_mode;
    logic [7:0]             r_prev_mode;
    logic signed [DW-1:0]   r_sp, r_kp, r_ki, r_kd;
    logic [DW-1:0]          r_pwm_lim, r_int_lim, r_db;
    logic signed [DW-1:0]   r_enc_prev;
    logic signed [DW-1:0]   r_err, r_err_prev;
    logic signed [IW-1:0]   r_integral;
    logic signed [PW-1:0]   r_prod_p, r_prod_i, r_prod_d;
    logic signed [SW-1:0]   r_sum;
    logic signed [DW-1:0]   r_duty;
    logic                   r_duty_valid;

    logic                   w_mode_chg;
    logic signed [DW-1:0]   w_enc_ref;
    logic signed [EW-1:0]   w_meas, w_err_raw;
    logic signed [DW-1:0]   w_err_sat, w_err_db;
    logic [DW-1:0]          w_err_abs;
    logic signed [IW:0]     w_int_sum, w_int_lim;
    logic signed [IW-1:0]   w_int_new;
    logic signed [DW:0]     w_d;
    logic signed [SW-1:0]   w_sum, w_pwm_lim, w_clamp_src;
    logic signed [DW-1:0]   w_duty_new;
    logic                   w_over_cur;

    // Free-running update-rate divider; the wrap cycle is the tick
    assign w_tick = (r_tick_cnt == CNT_W'(TICK_PERIOD - 1));

    always_ff @(posedge CLK) begin
        if (reset || w_tick) r_tick_cnt <= '0;
        else                 r_tick_cnt <= r_tick_cnt + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Ticks arriving mid-computation are simply ignored
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:     if (w_tick) w_state_next = S_SAMPLE;
            S_SAMPLE:   w_state_next = S_DEADBAND;
            S_DEADBAND: w_state_next = S_MUL_P;
            S_MUL_P:    w_state_next = S_MUL_I;
            S_MUL_I:    w_state_next = S_MUL_D;
            S_MUL_D:    w_state_next = S_SUM;
            S_SUM:      w_state_next = S_CLAMP;
            S_CLAMP:    w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
    end

    // Measurement and saturated error from live inputs (consumed only in SAMPLE)
    always_comb begin
        w_mode_chg = (io_bus.control_mode != r_prev_mode);
        w_enc_ref  = w_mode_chg ? '0 : r_enc_prev;
        case (io_bus.control_mode)
            8'd0:    w_meas = EW'(io_bus.encoder0_position);
            8'd1:    w_meas = EW'(io_bus.encoder0_position) - EW'(w_enc_ref);
            8'd2:    w_meas = EW'(io_bus.displacement);
            default: w_meas = '0;
        endcase
        w_err_raw = EW'(io_bus.setpoint) - w_meas;
        if (w_err_raw > ERR_HI)      w_err_sat = DW'(ERR_HI);
        else if (w_err_raw < ERR_LO) w_err_sat = DW'(ERR_LO);
        else                         w_err_sat = DW'(w_err_raw);
    end

    // Deadband, integrator and derivative terms on the latched error
    always_comb begin
        w_err_abs = r_err[DW-1] ? DW'(-r_err) : DW'(r_err);
        w_err_db  = ((r_mode > 8'd2) || (w_err_abs <= r_db)) ? '0 : r_err;

        w_int_sum = (IW+1)'(r_integral) + (IW+1)'(r_err);
        w_int_lim = $signed({9'd0, r_int_lim});
        if (r_mode > 8'd2)               w_int_new = '0;
        else if (w_int_sum > w_int_lim)  w_int_new = IW'(w_int_lim);
        else if (w_int_sum < -w_int_lim) w_int_new = IW'(-w_int_lim);
        else                             w_int_new = IW'(w_int_sum);

        w_d = (DW+1)'(r_err) - (DW+1)'(r_err_prev);
    end

    // Output limiting; effective limit also capped to the signed 24-bit range
    always_comb begin
        w_sum       = (SW'(r_prod_p) + SW'(r_prod_i) + SW'(r_prod_d)) >>> FRAC_BITS;
        w_pwm_lim   = (r_pwm_lim > 24'd8388607) ? DUTY_MAX : $signed({26'd0, r_pwm_lim});
        w_clamp_src = (r_mode == 8'd3) ? SW'(r_sp) : r_sum;
        if (r_mode > 8'd3)                 w_duty_new = '0;
        else if (w_clamp_src > w_pwm_lim)  w_duty_new = DW'(w_pwm_lim);
        else if (w_clamp_src < -w_pwm_lim) w_duty_new = DW'(-w_pwm_lim);
        else                               w_duty_new = DW'(w_clamp_src);
    end

`ifdef PID_CURRENT_LIMIT_EN
    logic signed [15:0] r_cur, r_cur_lim;
    logic [16:0]        w_cur_abs, w_cur_lim;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cur     <= '0;
            r_cur_lim <= '0;
        end else if (r_state == S_SAMPLE) begin
            r_cur     <= io_bus.current;
            r_cur_lim <= io_bus.current_limit;
        end
    end

    // Negative limit reads as zero magnitude
    always_comb begin
        w_cur_abs  = r_cur[15] ? 17'(-17'(r_cur)) : 17'(r_cur);
        w_cur_lim  = r_cur_lim[15] ? '0 : 17'(r_cur_lim);
        w_over_cur = (w_cur_abs > w_cur_lim);
    end
`else
    logic w_unused_cur;
    assign w_unused_cur = ^{io_bus.current, io_bus.current_limit};
    assign w_over_cur   = 1'b0;
`endif

    // Sequential datapath: one pipeline step per FSM state
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_mode       <= '0;
            r_prev_mode  <= '0;
            r_sp         <= '0;
            r_kp         <= '0;
            r_ki         <= '0;
            r_kd         <= '0;
            r_pwm_lim    <= '0;
            r_int_lim    <= '0;
            r_db         <= '0;
            r_enc_prev   <= '0;
            r_err        <= '0;
            r_err_prev   <= '0;
            r_integral   <= '0;
            r_prod_p     <= '0;
            r_prod_i     <= '0;
            r_prod_d     <= '0;
            r_sum        <= '0;
            r_duty       <= '0;
            r_duty_valid <= 1'b0;
        end else begin
            r_duty_valid <= 1'b0;
            case (r_state)
                S_SAMPLE: begin
                    r_mode      <= io_bus.control_mode;
                    r_prev_mode <= io_bus.control_mode;
                    r_sp        <= io_bus.setpoint;
                    r_kp        <= io_bus.Kp;
                    r_ki        <= io_bus.Ki;
                    r_kd        <= io_bus.Kd;
                    r_pwm_lim   <= io_bus.PWMLimit;
                    r_int_lim   <= io_bus.IntegralLimit;
                    r_db        <= io_bus.deadband;
                    r_err       <= w_err_sat;
                    r_enc_prev  <= io_bus.encoder0_position;
                    if (w_mode_chg) begin
                        r_integral <= '0;
                        r_err_prev <= '0;
                    end
                end
                S_DEADBAND: r_err <= w_err_db;
                S_MUL_P:    r_prod_p <= PW'(r_kp) * PW'(r_err);
                S_MUL_I: begin
                    r_integral <= w_int_new;
                    r_prod_i   <= PW'(r_ki) * PW'(w_int_new);
                end
                S_MUL_D: begin
                    r_prod_d   <= PW'(r_kd) * PW'(w_d);
                    r_err_prev <= r_err;
                end
                S_SUM:      r_sum <= w_sum;
                S_CLAMP: begin
                    r_duty       <= w_over_cur ? '0 : w_duty_new;
                    r_duty_valid <= 1'b1;
                    if (w_over_cur) r_integral <= '0;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.duty       = r_duty;
    assign io_bus.duty_valid = r_duty_valid;

endmodule

// File: tb/tb_pid_controller.sv
// tb_pid_controller: directed test-plan cases plus randomized updates against a behavioural PID model.
module tb_pid_controller;
    localparam int PERIOD = 32;
    localparam int FRAC   = 0;

    logic CLK   = 1'b0;
    logic reset = 1'b1;
    int   n_edge = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   last_ref = 0;
    int   exp_gap = 0;

    pid_controller_if bus();

    pid_controller #(
        .CLK_FREQ_HZ   (PERIOD),
        .UPDATE_FREQ_HZ(1),
        .FRAC_BITS     (FRAC)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .io_bus(bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) n_edge <= n_edge + 1;

    // Stimulus values for the next update
    int     s_mode;
    longint s_sp, s_kp, s_ki, s_kd, s_pwm, s_il, s_db, s_cl, s_enc, s_disp, s_cur;

    // Reference model state
    longint m_integral, m_err_prev, m_enc_prev;
    int     m_prev_mode;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v, input longint lim);
        if (v > lim)  return lim;
        if (v < -lim) return -lim;
        return v;
    endfunction

    function automatic longint absv(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_integral = 0; m_err_prev = 0; m_enc_prev = 0; m_prev_mode = 0;
    endtask

    // One control update computed directly from the behavioural rules
    task automatic model_step(output longint duty);
        longint meas, err, d, lim, clim;
        if (s_mode != m_prev_mode) begin
            m_integral = 0; m_err_prev = 0; m_enc_prev = 0;
        end
        m_prev_mode = s_mode;
        case (s_mode)
            0:       meas = s_enc;
            1:       meas = s_enc - m_enc_prev;
            2:       meas = s_disp;
            default: meas = 0;
        endcase
        m_enc_prev = s_enc;
        lim = (s_pwm > 8388607) ? 8388607 : s_pwm;
        if (s_mode <= 2) begin
            err = sat(s_sp - meas, 8388607);
            if (absv(err) <= s_db) err = 0;
            m_integral = sat(m_integral + err, s_il);
            d = err - m_err_prev;
            m_err_prev = err;
            duty = sat((s_kp * err + s_ki * m_integral + s_kd * d) >>> FRAC, lim);
        end else begin
            m_integral = 0;
            m_err_prev = 0;
            duty = (s_mode == 3) ? sat(s_sp, lim) : 0;
        end
`ifdef PID_CURRENT_LIMIT_EN
        clim = (s_cl < 0) ? 0 : s_cl;
        if (absv(s_cur) > clim) begin
            duty = 0;
            m_integral = 0;
        end
`else
        clim = 0;
`endif
    endtask

    task automatic drive();
        bus.control_mode      = 8'(s_mode);
        bus.setpoint          = 24'(s_sp);
        bus.Kp                = 24'(s_kp);
        bus.Ki                = 24'(s_ki);
        bus.Kd                = 24'(s_kd);
        bus.PWMLimit          = 24'(s_pwm);
        bus.IntegralLimit     = 24'(s_il);
        bus.deadband          = 24'(s_db);
        bus.current_limit     = 16'(s_cl);
        bus.encoder0_position = 24'(s_enc);
        bus.displacement      = 24'(s_disp);
        bus.current           = 16'(s_cur);
    endtask

    task automatic scramble();
        bus.control_mode      = 8'($urandom);
        bus.setpoint          = 24'($urandom);
        bus.Kp                = 24'($urandom);
        bus.Ki                = 24'($urandom);
        bus.Kd                = 24'($urandom);
        bus.PWMLimit          = 24'($urandom);
        bus.IntegralLimit     = 24'($urandom);
        bus.deadband          = 24'($urandom);
        bus.current_limit     = 16'($urandom);
        bus.encoder0_position = 24'($urandom);
        bus.displacement      = 24'($urandom);
        bus.current           = 16'($urandom);
    endtask

    // Waits for the next duty_valid; optionally corrupts inputs mid-computation
    task automatic wait_valid(input int budget, input int scr_at, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge CLK); #1;
            if (i == scr_at) scramble();
            if (bus.duty_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input bit directed, input longint exp_c,
                           input bit scr);
        longint exp_m;
        bit     got;
        drive();
        model_step(exp_m);
        wait_valid(2 * PERIOD, scr ? 26 : -1, got);
        check({tag, "_seen"}, longint'(got), 1);
        if (got) begin
            check({tag, "_lat"}, longint'(n_edge - last_ref), longint'(exp_gap));
            check(tag, longint'(bus.duty), directed ? exp_c : exp_m);
            last_ref = n_edge;
            exp_gap  = PERIOD;
            @(posedge CLK); #1;
            check({tag, "_pulse"}, longint'(bus.duty_valid), 0);
        end
    endtask

    function automatic longint rs(input int unsigned m);
        return longint'($urandom_range(2 * m)) - longint'(m);
    endfunction

    task automatic set_base(input int mode, input longint kp, input longint ki, input longint kd,
                            input longint pwm, input longint il, input longint db);
        s_mode = mode; s_kp = kp; s_ki = ki; s_kd = kd;
        s_pwm = pwm; s_il = il; s_db = db;
        s_cl = 0; s_cur = 0; s_disp = 0;
    endtask

    initial begin
        bit early;
        s_sp = 0; s_enc = 0;
        set_base(0, 0, 0, 0, 0, 0, 0);
        drive();
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_duty", longint'(bus.duty), 0);
        check("rst_valid", longint'(bus.duty_valid), 0);
        reset    = 1'b0;
        last_ref = n_edge;
        exp_gap  = PERIOD + 7;

        // Proportional path and output clamp
        set_base(0, 10, 0, 0, 500, 0, 0);
        s_enc = 40; s_sp = 60;  run_txn("p_200", 1, 200, 0);
        s_sp = 100;             run_txn("p_clamp", 1, 500, 0);

        // Integrator with limit, then mode switch clears it
        set_base(0, 0, 1, 0, 500, 50, 0);
        s_sp = 70;              run_txn("i_30", 1, 30, 0);
                                run_txn("i_50a", 1, 50, 0);
                                run_txn("i_50b", 1, 50, 0);
        s_mode = 2; s_disp = 70; run_txn("i_mode2", 1, 0, 0);
        s_mode = 0; s_disp = 0;  run_txn("i_restart", 1, 30, 0);

        // Deadband and derivative
        set_base(0, 10, 0, 0, 500, 0, 5);
        s_sp = 44;              run_txn("db_in", 1, 0, 0);
        s_sp = 34;              run_txn("db_out", 1, -60, 0);
        s_kp = 0; s_kd = 2;
        s_sp = 40;              run_txn("d_zero", 0, 0, 0);
        s_sp = 50;              run_txn("d_step", 1, 20, 0);
                                run_txn("d_hold", 1, 0, 0);

        // Direct duty and disabled modes
        set_base(3, 0, 0, 0, 500, 0, 0);
        s_sp = -700;            run_txn("m3_neg", 1, -500, 0);
        s_sp = 123;             run_txn("m3_pass", 1, 123, 0);
        s_mode = 7;             run_txn("m7_off", 1, 0, 0);

        // Over-current cutoff
        set_base(0, 10, 0, 0, 500, 0, 0);
        s_sp = 60; s_enc = 40; s_cl = 100;
        s_cur = 101;
`ifdef PID_CURRENT_LIMIT_EN
        run_txn("cur_over", 1, 0, 0);
`else
        run_txn("cur_over", 1, 200, 0);
`endif
        s_cur = -100;           run_txn("cur_edge", 1, 200, 0);

        // Zero output limit, then error saturation at full scale
        s_cur = 0; s_pwm = 0;   run_txn("pwm0", 1, 0, 0);
        set_base(0, 1, 0, 0, 24'hFFFFFF, 0, 0);
        s_sp = 8388607; s_enc = -8388608;
        run_txn("err_sat", 1, 8388607, 0);

        // Reset in the middle of an update aborts it
        early = 1'b0;
        for (int i = 0; i < 27; i++) begin
            @(posedge CLK); #1;
            if (bus.duty_valid === 1'b1) early = 1'b1;
        end
        check("pre_rst_valid", longint'(early), 0);
        reset = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        check("mid_rst_duty", longint'(bus.duty), 0);
        check("mid_rst_valid", longint'(bus.duty_valid), 0);
        reset    = 1'b0;
        last_ref = n_edge;
        exp_gap  = PERIOD + 7;
        model_reset();
        set_base(0, 10, 0, 0, 500, 0, 0);
        s_sp = 60; s_enc = 40;  run_txn("post_rst", 1, 200, 0);

        // Randomized updates, some with inputs disturbed mid-computation
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1) == 0) begin
                case ($urandom_range(5))
                    0, 1:    s_mode = 0;
                    2:       s_mode = 1;
                    3:       s_mode = 2;
                    4:       s_mode = 3;
                    default: s_mode = 6;
                endcase
            end
            s_sp   = rs(100000);
            s_enc  = rs(100000);
            s_disp = rs(100000);
            s_kp   = rs(300);
            s_ki   = rs(300);
            s_kd   = rs(300);
            s_pwm  = ($urandom_range(7) == 0) ? 0 : longint'($urandom_range(2000000));
            s_il   = ($urandom_range(7) == 0) ? 0 : longint'($urandom_range(500000));
            s_db   = longint'($urandom_range(2000));
            s_cur  = rs(200);
            s_cl   = rs(150);
            run_txn("rnd", 0, 0, ($urandom_range(3) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
